// File: rtl/control_sequencer.sv
// control_sequencer: instruction register plus T0..T3 step counter, decoding
// mv / mvi / add / sub / mvnz / and and trapping the two undefined opcodes.
// Every datapath strobe is combinational from the step, IR, Run and GNZ.
module control_sequencer #(
  parameter int RBITS = 3,
  parameter int DW    = 9,
  localparam int NREG = 2**RBITS,
  localparam int IRW  = 3 + 2*RBITS
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [DW-1:0]   DIN,
  input  logic            GNZ,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic            DINout,
  output logic [1:0]      AluOp,
  output logic            Done,
  output logic            Busy,
  output logic            Illegal,
  output logic [1:0]      Tstep
);

  // The instruction word must fit in the data bus.
  if (DW < IRW) begin : g_bad_dw
    $error("control_sequencer: DW must be >= 3+2*RBITS");
  end

  // Bits of DIN above the instruction field are only meaningful as mvi data,
  // which travels over the bus, not through this block.
  if (DW > IRW) begin : g_unused_hi
    logic unused_din_hi;
    assign unused_din_hi = ^DIN[DW-1:IRW];
  end

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;

  step_e            step_q, step_d;
  logic [IRW-1:0]   ir_q, ir_d;

  logic [2:0]       opcode;
  logic [RBITS-1:0] rx, ry;
  logic [NREG-1:0]  rx_oh, ry_oh;
  logic             is_alu;
  logic [1:0]       alu_sel;

  assign opcode = ir_q[2:0];
  assign rx     = ir_q[2+RBITS:3];
  assign ry     = ir_q[IRW-1:3+RBITS];
  assign rx_oh  = {{(NREG-1){1'b0}}, 1'b1} << rx;
  assign ry_oh  = {{(NREG-1){1'b0}}, 1'b1} << ry;
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

  // ALU function select for the T2 step of add/sub/and.
  always_comb begin
    alu_sel = 2'b00;
    case (opcode)
      OP_SUB:  alu_sel = 2'b01;
      OP_AND:  alu_sel = 2'b10;
      default: alu_sel = 2'b00;
    endcase
  end

  // Step decode, datapath strobes and next-state; Reset masks all outputs.
  always_comb begin
    IRin    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    DINout  = 1'b0;
    AluOp   = 2'b00;
    Done    = 1'b0;
    Illegal = 1'b0;
    ir_d    = ir_q;
    step_d  = step_q;

    unique case (step_q)
      T0: begin
        if (Run) begin
          IRin = 1'b1;
          ir_d = DIN[IRW-1:0];
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            Rout = ry_oh;
            Rin  = rx_oh;
            Done = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = rx_oh;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            Rout = rx_oh;
            Ain  = 1'b1;
          end
          OP_MVNZ: begin
            if (GNZ) begin
              Rout = ry_oh;
              Rin  = rx_oh;
            end
            Done = 1'b1;
          end
          default: begin
            Done    = 1'b1;
            Illegal = 1'b1;
          end
        endcase
      end
      T2: begin
        // Only ALU ops reach T2; anything else just retires.
        if (is_alu) begin
          Rout  = ry_oh;
          Gin   = 1'b1;
          AluOp = alu_sel;
        end else begin
          Done = 1'b1;
        end
      end
      T3: begin
        if (is_alu) begin
          Gout = 1'b1;
          Rin  = rx_oh;
        end
        Done = 1'b1;
      end
      default: ;
    endcase

    if (Done)
      step_d = T0;
    else if (step_q != T0 || Run)
      step_d = step_e'(step_q + 2'd1);

    if (Reset) begin
      IRin    = 1'b0;
      Rin     = '0;
      Rout    = '0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      DINout  = 1'b0;
      AluOp   = 2'b00;
      Done    = 1'b0;
      Illegal = 1'b0;
    end
  end

  assign Busy  = !Reset && (step_q != T0);
  assign Tstep = Reset ? 2'd0 : step_q;

  // Step counter and instruction register, synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

endmodule
